// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus: single-outstanding req/gnt, then rvalid/rdata.
interface fetch_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  imem_req;
    logic [DATA_WIDTH-1:0] imem_addr;
    logic                  imem_gnt;
    logic                  imem_rvalid;
    logic [DATA_WIDTH-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// RV32I instruction-fetch stage: owns the PC, fetches one instruction at a time over the
// imem bus, redirects on Execute-resolved branches and feeds IF/ID (NOP bubble when idle).
module fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  PCSrcE,
    input  logic [DATA_WIDTH-1:0] PCTargetE,
    fetch_unit_if.master          imem,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] PCf,
    output logic [DATA_WIDTH-1:0] PCPlus4F,
    output logic                  InstrValidF
);

    typedef enum logic [1:0] {REQ, WAIT, HOLD} state_t;

    state_t                state, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] buf_q, buf_d;
    logic                  discard_q, discard_d;
    logic [DATA_WIDTH-1:0] redirect_pc;

    // Branch targets are forced word-aligned.
    assign redirect_pc = PCTargetE & ~DATA_WIDTH'(3);

    assign PCf            = pc_q;
    assign PCPlus4F       = pc_q + DATA_WIDTH'(4);
    assign imem.imem_addr = pc_q;
    assign imem.imem_req  = (state == REQ) && !PCSrcE && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= REQ;
            pc_q      <= RESET_PC;
            discard_q <= 1'b0;
            buf_q     <= '0;
        end else begin
            state     <= state_d;
            pc_q      <= pc_d;
            discard_q <= discard_d;
            buf_q     <= buf_d;
        end
    end

    always_comb begin
        state_d     = state;
        pc_d        = pc_q;
        buf_d       = buf_q;
        discard_d   = discard_q;
        InstrValidF = 1'b0;
        instr       = NOP_INSTR;

        if (PCSrcE) begin
            pc_d = redirect_pc;
            // A response still in flight belongs to the squashed path: wait it out and drop it.
            if (state == WAIT && !imem.imem_rvalid) begin
                state_d   = WAIT;
                discard_d = 1'b1;
            end else begin
                state_d   = REQ;
                discard_d = 1'b0;
            end
        end else begin
            unique case (state)
                REQ: begin
                    if (imem.imem_gnt) state_d = WAIT;
                end
                WAIT: begin
                    if (imem.imem_rvalid) begin
                        if (discard_q) begin
                            discard_d = 1'b0;
                            state_d   = REQ;
                        end else begin
                            InstrValidF = 1'b1;
                            instr       = imem.imem_rdata;
                            if (!stall) begin
                                pc_d    = pc_q + DATA_WIDTH'(4);
                                state_d = REQ;
                            end else begin
                                buf_d   = imem.imem_rdata;
                                state_d = HOLD;
                            end
                        end
                    end
                end
                HOLD: begin
                    InstrValidF = 1'b1;
                    instr       = buf_q;
                    if (!stall) begin
                        pc_d    = pc_q + DATA_WIDTH'(4);
                        state_d = REQ;
                    end
                end
                default: state_d = REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic against a transaction-level model.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic [31:0] instr;
    logic [31:0] PCf;
    logic [31:0] PCPlus4F;
    logic        InstrValidF;

    fetch_unit_if #(.DATA_WIDTH(32)) bus ();

    fetch_unit #(
        .DATA_WIDTH(32),
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (NOP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .PCSrcE     (PCSrcE),
        .PCTargetE  (PCTargetE),
        .imem       (bus),
        .instr      (instr),
        .PCf        (PCf),
        .PCPlus4F   (PCPlus4F),
        .InstrValidF(InstrValidF)
    );

    int n_cmp = 0;
    int n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] tag(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, required %h", name, $time, act, exp);
        end
    endtask

    // ---------------- memory responder ----------------
    bit          mem_pend    = 0;
    bit          mem_rv_real = 0;
    int          mem_cnt     = 0;
    logic [31:0] mem_addr    = '0;
    int          mem_lat     = 1;   // 0 = random latency 1..4
    bit          gnt_block   = 0;
    bit          gnt_rand    = 0;
    bit          spur_en     = 0;

    initial begin
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
    end

    always @(posedge clk) begin
        #2;
        mem_rv_real     = mem_pend && (mem_cnt == 0);
        bus.imem_rvalid = mem_rv_real;
        bus.imem_rdata  = tag(mem_addr);
        if (!mem_pend && spur_en && $urandom_range(0, 7) == 0) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = $urandom;
        end
        bus.imem_gnt = bus.imem_req && !mem_pend && !gnt_block &&
                       (!gnt_rand || $urandom_range(0, 1) == 1);
    end

    always @(negedge clk) begin
        if (mem_rv_real) mem_pend = 0;
        else if (mem_pend) mem_cnt--;
        if (bus.imem_gnt && bus.imem_req) begin
            mem_pend = 1;
            mem_addr = bus.imem_addr;
            mem_cnt  = (mem_lat == 0) ? int'($urandom_range(0, 3)) : mem_lat - 1;
        end
    end

    // ---------------- reference model and per-cycle compare ----------------
    logic [31:0] m_pc    = '0;
    logic [31:0] m_hdata = '0;
    bit          m_out   = 0;   // a request has been accepted and its data is still due
    bit          m_stale = 0;   // that due data belongs to a squashed path
    bit          m_held  = 0;   // a fetched instruction is parked while stalled

    always @(negedge clk) begin
        logic        e_req, e_valid, fresh;
        logic [31:0] e_instr;
        if (rst) begin
            m_pc = '0; m_out = 0; m_stale = 0; m_held = 0;
        end
        fresh   = m_out && bus.imem_rvalid && !m_stale && !PCSrcE;
        e_req   = !rst && !m_out && !m_held && !PCSrcE;
        e_valid = !rst && !PCSrcE && (m_held || fresh);
        e_instr = !e_valid ? NOP : (m_held ? m_hdata : bus.imem_rdata);

        chk("imem_req", {31'd0, bus.imem_req}, {31'd0, e_req});
        chk("imem_addr", bus.imem_addr, m_pc);
        chk("PCf", PCf, m_pc);
        chk("PCPlus4F", PCPlus4F, m_pc + 32'd4);
        chk("InstrValidF", {31'd0, InstrValidF}, {31'd0, e_valid});
        chk("instr", instr, e_instr);
        if (InstrValidF) chk("instr_tag", instr, tag(PCf));

        if (rst) begin
            // stay in reset
        end else if (PCSrcE) begin
            m_pc = {PCTargetE[31:2], 2'b00};
            if (m_out && !bus.imem_rvalid) m_stale = 1;
            else begin m_out = 0; m_stale = 0; end
            m_held = 0;
        end else if (m_held) begin
            if (!stall) begin m_held = 0; m_pc = m_pc + 32'd4; end
        end else if (m_out) begin
            if (bus.imem_rvalid) begin
                m_out = 0;
                if (m_stale) m_stale = 0;
                else if (!stall) m_pc = m_pc + 32'd4;
                else begin m_held = 1; m_hdata = bus.imem_rdata; end
            end
        end else if (bus.imem_gnt && e_req) begin
            m_out = 1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic s, input logic br, input logic [31:0] t, input logic r);
        @(posedge clk);
        #1;
        stall = s; PCSrcE = br; PCTargetE = t; rst = r;
        #3;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; PCSrcE = 1'b0; PCTargetE = '0;

        // reset state
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
        chk("rst_valid", {31'd0, InstrValidF}, 32'd0);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_pc", PCf, 32'h0);

        // zero-wait streaming, stall of 3 cycles on the data for PC=8
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 0);
            chk("seq_addr", bus.imem_addr, 32'(4 * i));
            chk("seq_req", {31'd0, bus.imem_req}, 32'd1);
            chk("seq_gap_valid", {31'd0, InstrValidF}, 32'd0);
            cyc(i == 2, 0, 0, 0);
            chk("seq_valid", {31'd0, InstrValidF}, 32'd1);
            chk("seq_instr", instr, tag(32'(4 * i)));
            chk("seq_plus4", PCPlus4F, 32'(4 * i + 4));
            if (i == 2) begin
                for (int k = 0; k < 2; k++) begin
                    cyc(1, 0, 0, 0);
                    chk("hold_instr", instr, tag(32'h8));
                    chk("hold_pc", PCf, 32'h8);
                end
                cyc(0, 0, 0, 0);
                chk("hold_rel_instr", instr, tag(32'h8));
                chk("hold_rel_valid", {31'd0, InstrValidF}, 32'd1);
            end
        end

        // redirect to 0x40 while waiting, data arrives two cycles later
        mem_lat = 3;
        cyc(0, 0, 0, 0);
        chk("wait_addr", bus.imem_addr, 32'h10);
        cyc(0, 1, 32'h40, 0);
        chk("redir_wait_valid", {31'd0, InstrValidF}, 32'd0);
        cyc(0, 0, 0, 0);
        chk("redir_wait_addr", bus.imem_addr, 32'h40);
        mem_lat = 1;
        cyc(0, 0, 0, 0);
        chk("stale_valid", {31'd0, InstrValidF}, 32'd0);
        chk("stale_instr", instr, NOP);
        cyc(0, 0, 0, 0);
        chk("after_stale_addr", bus.imem_addr, 32'h40);
        chk("after_stale_req", {31'd0, bus.imem_req}, 32'd1);

        // redirect coinciding with rvalid
        cyc(0, 1, 32'h80, 0);
        chk("redir_rv_valid", {31'd0, InstrValidF}, 32'd0);
        cyc(0, 0, 0, 0);
        chk("redir_rv_pc", PCf, 32'h80);

        // redirect while holding, unaligned target 0x43
        cyc(1, 0, 0, 0);
        chk("pre_hold_instr", instr, tag(32'h80));
        cyc(1, 1, 32'h43, 0);
        chk("redir_hold_valid", {31'd0, InstrValidF}, 32'd0);
        mem_lat = 3;
        cyc(0, 0, 0, 0);
        chk("align_pc", PCf, 32'h40);

        // reset while waiting, stray rvalid afterwards
        cyc(0, 0, 0, 1);
        chk("rst_wait_pc", PCf, 32'h0);
        chk("rst_wait_req", {31'd0, bus.imem_req}, 32'd0);
        mem_lat = 1;
        cyc(0, 0, 0, 0);
        chk("post_rst_addr", bus.imem_addr, 32'h0);
        cyc(0, 0, 0, 0);
        chk("stray_valid", {31'd0, InstrValidF}, 32'd0);
        chk("stray_instr", instr, NOP);
        cyc(0, 0, 0, 0);
        chk("post_rst_req", {31'd0, bus.imem_req}, 32'd1);
        cyc(0, 0, 0, 0);
        chk("post_rst_instr", instr, tag(32'h0));

        // grant withheld for 4 cycles
        gnt_block = 1;
        for (int k = 0; k < 4; k++) begin
            cyc(0, 0, 0, 0);
            chk("nognt_req", {31'd0, bus.imem_req}, 32'd1);
            chk("nognt_addr", bus.imem_addr, 32'h4);
            chk("nognt_instr", instr, 32'h0000_0013);
        end
        gnt_block = 0;
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("after_gnt_instr", instr, tag(32'h4));

        // PC wrap at the top of the address space
        cyc(0, 1, 32'hFFFF_FFFC, 0);
        cyc(0, 0, 0, 0);
        chk("wrap_pc", PCf, 32'hFFFF_FFFC);
        chk("wrap_plus4", PCPlus4F, 32'h0);
        cyc(0, 0, 0, 0);
        chk("wrap_instr", instr, tag(32'hFFFF_FFFC));
        cyc(0, 0, 0, 0);
        chk("wrap_next_pc", PCf, 32'h0);

        // randomized traffic
        mem_lat  = 0;
        gnt_rand = 1;
        spur_en  = 1;
        for (int n = 0; n < 4000; n++) begin
            logic [31:0] t;
            t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                            : $urandom;
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, t,
                $urandom_range(0, 255) == 0);
        end
        spur_en = 0;
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
